// File: rtl/servo_key_pacer.sv
`default_nettype none
// ============================================================================
// Module   : servo_key_pacer
// Brief    : Debounces eight active-low buttons and issues one-cycle command
//            codes (CODE_BASE+i) on press and on auto-repeat while held.
// Revision : 1.0 - initial release
// ============================================================================
module servo_key_pacer #(
  parameter int DEBOUNCE_CYCLES      = 1000000,
  parameter int REPEAT_DELAY_CYCLES  = 25000000,
  parameter int REPEAT_PERIOD_CYCLES = 5000000,
  parameter int CODE_BASE            = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] btn_n,
  output logic [7:0] key_code,
  output logic       key_valid
);

  localparam int c_TMR_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                             REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);
  localparam int c_DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [c_DEB_W-1:0] c_DEB_LAST    = c_DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_DEB_W-1:0] c_DEB_ONE     = c_DEB_W'(1);
  localparam logic [c_TMR_W-1:0] c_DELAY_LAST  = c_TMR_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [c_TMR_W-1:0] c_PERIOD_LAST = c_TMR_W'(REPEAT_PERIOD_CYCLES - 1);
  localparam logic [c_TMR_W-1:0] c_TMR_ONE     = c_TMR_W'(1);
  localparam logic [7:0]         c_CODE_BASE   = 8'(CODE_BASE);

  generate
    if (CODE_BASE < 0 || CODE_BASE + 7 > 255) begin : g_bad_code_base
      $error("servo_key_pacer: CODE_BASE+7 must fit in 8 bits");
    end
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY_CYCLES < 1 || REPEAT_PERIOD_CYCLES < 1) begin : g_bad_cycles
      $error("servo_key_pacer: cycle parameters must be at least 1");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Two-flop synchronizer, released state is all ones
  // --------------------------------------------------------------------------
  logic [7:0] r_sync1;
  logic [7:0] r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 8'hFF;
      r_sync2 <= 8'hFF;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
    end
  end

  // --------------------------------------------------------------------------
  // Whole-vector debounce; kept in active-low polarity so reset means released
  // --------------------------------------------------------------------------
  logic [7:0]         r_cand_n;
  logic [7:0]         r_deb_n;
  logic [c_DEB_W-1:0] r_deb_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand_n  <= 8'hFF;
      r_deb_n   <= 8'hFF;
      r_deb_cnt <= '0;
    end else if (r_sync2 != r_cand_n) begin
      r_cand_n  <= r_sync2;
      r_deb_cnt <= '0;
    end else if (r_deb_cnt == c_DEB_LAST) begin
      r_deb_n   <= r_cand_n;
    end else begin
      r_deb_cnt <= r_deb_cnt + c_DEB_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Single-button decode; chords and no-press give no selection
  // --------------------------------------------------------------------------
  logic [7:0] w_pressed;
  logic       w_valid_sel;
  logic [2:0] w_sel;

  always_comb begin
    w_pressed   = ~r_deb_n;
    w_valid_sel = (w_pressed != 8'h00) && ((w_pressed & (w_pressed - 8'h01)) == 8'h00);
    w_sel       = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (w_pressed[i]) begin
        w_sel = 3'(i);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Press / repeat pacing FSM
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2:0]         r_cur;
  logic [2:0]         w_cur_nxt;
  logic [c_TMR_W-1:0] r_tmr;
  logic [c_TMR_W-1:0] w_tmr_nxt;
  logic               w_emit;
  logic [2:0]         w_emit_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cur   <= 3'd0;
      r_tmr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_tmr   <= w_tmr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_tmr_nxt   = r_tmr;
    w_emit      = 1'b0;
    w_emit_sel  = r_cur;
    case (r_state)
      S_IDLE: begin
        if (w_valid_sel) begin
          w_emit      = 1'b1;
          w_emit_sel  = w_sel;
          w_cur_nxt   = w_sel;
          w_tmr_nxt   = '0;
          w_state_nxt = S_DELAY;
        end
      end
      S_DELAY: begin
        if (!w_valid_sel || (w_sel != r_cur)) begin
          w_state_nxt = S_IDLE;
        end else if (r_tmr == c_DELAY_LAST) begin
          w_emit      = 1'b1;
          w_tmr_nxt   = '0;
          w_state_nxt = S_REPEAT;
        end else begin
          w_tmr_nxt   = r_tmr + c_TMR_ONE;
        end
      end
      S_REPEAT: begin
        if (!w_valid_sel || (w_sel != r_cur)) begin
          w_state_nxt = S_IDLE;
        end else if (r_tmr == c_PERIOD_LAST) begin
          w_emit      = 1'b1;
          w_tmr_nxt   = '0;
        end else begin
          w_tmr_nxt   = r_tmr + c_TMR_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered outputs guarantee a single-cycle code per event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code  <= 8'h00;
      key_valid <= 1'b0;
    end else begin
      key_code  <= w_emit ? (c_CODE_BASE + {5'd0, w_emit_sel}) : 8'h00;
      key_valid <= w_emit;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_servo_key_pacer.sv
`default_nettype none
// ============================================================================
// Module   : tb_servo_key_pacer
// Brief    : Self-checking bench for servo_key_pacer with a run-length model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_servo_key_pacer;

  localparam int c_DEB = 4;
  localparam int c_RD  = 10;
  localparam int c_RP  = 3;
  localparam int c_CB  = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] btn_n;
  logic [7:0] key_code;
  logic       key_valid;

  servo_key_pacer #(
    .DEBOUNCE_CYCLES      (c_DEB),
    .REPEAT_DELAY_CYCLES  (c_RD),
    .REPEAT_PERIOD_CYCLES (c_RP),
    .CODE_BASE            (c_CB)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_n     (btn_n),
    .key_code  (key_code),
    .key_valid (key_valid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: pin history, run length of the pressed vector, and hold age of the
  // debounced selection from which emission times follow arithmetically.
  logic [7:0] m_sy [2];
  logic [7:0] m_plast;
  int         m_prun;
  logic [7:0] m_deb;
  bit         m_prev_valid;
  int         m_sel;
  int         m_age;
  int         m_off;
  logic [7:0] exp_code;
  logic       exp_valid;

  typedef struct {
    int         cyc;
    logic [7:0] code;
  } ev_t;
  ev_t ev_q[$];

  typedef struct {
    logic [7:0] btn;
    int         hold;
    int         pulses;
    logic [7:0] code;
    int         first;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    m_sy[0]      = 8'hFF;
    m_sy[1]      = 8'hFF;
    m_plast      = 8'h00;
    m_prun       = 1;
    m_deb        = 8'h00;
    m_prev_valid = 1'b0;
    m_sel        = 0;
    m_age        = 0;
    m_off        = 0;
    exp_code     = 8'h00;
    exp_valid    = 1'b0;
  endtask

  task automatic model_edge(input logic [7:0] b);
    logic [7:0] p;
    int         t;
    int         s;
    bit         v;
    v         = ($countones(m_deb) == 1);
    exp_code  = 8'h00;
    exp_valid = 1'b0;
    if (v) begin
      s = 0;
      for (int i = 0; i < 8; i++) if (m_deb[i]) s = i;
      if (m_prev_valid && s == m_sel) begin
        m_age++;
      end else begin
        // switching straight from another button costs one idle cycle
        m_off = m_prev_valid ? 1 : 0;
        m_age = 0;
        m_sel = s;
      end
      t = m_age - m_off;
      if (t == 0 || (t >= c_RD && (t - c_RD) % c_RP == 0)) begin
        exp_valid = 1'b1;
        exp_code  = 8'(c_CB + s);
      end
    end
    m_prev_valid = v;
    p       = ~m_sy[0];
    m_sy[0] = m_sy[1];
    m_sy[1] = b;
    if (p == m_plast) begin
      if (m_prun < 1000) m_prun++;
    end else begin
      m_plast = p;
      m_prun  = 1;
    end
    if (m_prun >= c_DEB + 1) m_deb = p;
  endtask

  task automatic step();
    logic [7:0] b;
    b = btn_n;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) model_reset();
    else        model_edge(b);
    check("key_code", key_code, exp_code);
    check("key_valid", key_valid, exp_valid);
    if (key_valid) ev_q.push_back('{cyc, key_code});
  endtask

  function automatic int count_code(input logic [7:0] c);
    int n = 0;
    foreach (ev_q[i]) if (ev_q[i].code == c) n++;
    return n;
  endfunction

  function automatic int first_edge(input logic [7:0] c, input int base);
    foreach (ev_q[i]) if (ev_q[i].code == c) return ev_q[i].cyc - base - 1;
    return -1;
  endfunction

  function automatic int last_edge(input logic [7:0] c, input int base);
    int e = -1;
    foreach (ev_q[i]) if (ev_q[i].code == c) e = ev_q[i].cyc - base - 1;
    return e;
  endfunction

  initial begin
    int base;
    int f11;

    tbl[0] = '{~8'h01,  8, 1, 8'd6,  7};
    tbl[1] = '{~8'h80, 30, 8, 8'd13, 7};
    tbl[2] = '{~8'h04, 18, 4, 8'd8,  7};
    tbl[3] = '{~8'h08, 16, 3, 8'd9,  7};
    tbl[4] = '{~8'h08, 17, 4, 8'd9,  7};
    tbl[5] = '{~8'h20,  4, 0, 8'd11, -1};
    tbl[6] = '{~8'h20,  5, 1, 8'd11, 7};
    tbl[7] = '{~8'h0A, 40, 0, 8'd0,  -1};

    rst_n = 1'b0;
    btn_n = 8'hFF;
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (10) step();

    // Table: press pattern, hold, count pulses and their timing
    for (int r = 0; r < 8; r++) begin
      ev_q.delete();
      base  = cyc;
      btn_n = tbl[r].btn;
      repeat (tbl[r].hold) step();
      btn_n = 8'hFF;
      repeat (20) step();
      check($sformatf("row%0d pulses", r), ev_q.size(), tbl[r].pulses);
      foreach (ev_q[i]) check($sformatf("row%0d code", r), ev_q[i].code, tbl[r].code);
      if (tbl[r].pulses > 0 && ev_q.size() > 0)
        check($sformatf("row%0d first", r), ev_q[0].cyc - base - 1, tbl[r].first);
      if (tbl[r].pulses >= 3 && ev_q.size() >= 3) begin
        check($sformatf("row%0d delay", r), ev_q[1].cyc - ev_q[0].cyc, 10);
        check($sformatf("row%0d period", r), ev_q[2].cyc - ev_q[1].cyc, 3);
      end
    end

    // Bounce shorter than the debounce window
    ev_q.delete();
    for (int i = 0; i < 10; i++) begin
      btn_n = (i % 2 == 0) ? ~8'h10 : 8'hFF;
      repeat (2) step();
    end
    btn_n = 8'hFF;
    repeat (15) step();
    check("bounce codes", ev_q.size(), 0);

    // Chord then release one button of it
    ev_q.delete();
    base  = cyc;
    btn_n = ~8'h0A;
    repeat (40) step();
    btn_n = ~8'h02;
    repeat (15) step();
    btn_n = 8'hFF;
    repeat (20) step();
    check("chord total", ev_q.size(), 3);
    check("chord code7", count_code(8'd7), 3);
    check("chord first7", first_edge(8'd7, base), 47);

    // Direct switch from button 2 to button 5 while repeating
    ev_q.delete();
    base  = cyc;
    btn_n = ~8'h04;
    repeat (25) step();
    btn_n = ~8'h20;
    repeat (20) step();
    btn_n = 8'hFF;
    repeat (20) step();
    check("switch code8", count_code(8'd8), 6);
    check("switch code11", count_code(8'd11), 4);
    f11 = first_edge(8'd11, base);
    check("switch first11", f11, 33);
    check("switch gap", f11 - last_edge(8'd8, base), 4);

    // Asynchronous reset while a code is on the output
    btn_n = ~8'h04;
    for (int i = 0; i < 40 && !key_valid; i++) step();
    check("reset pre valid", key_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset async code", key_code, 0);
    check("reset async valid", key_valid, 0);
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
    ev_q.delete();
    base = cyc;
    repeat (8) step();
    btn_n = 8'hFF;
    repeat (20) step();
    check("reset after count", count_code(8'd8), 1);
    check("reset after total", ev_q.size(), 1);
    check("reset after first", first_edge(8'd8, base), 7);

    // Random press/hold/chord traffic against the model
    for (int s = 0; s < 60; s++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k < 6)      btn_n = ~(8'h01 << $urandom_range(0, 7));
      else if (k < 8) btn_n = 8'hFF;
      else            btn_n = 8'($urandom);
      if (s == 30) begin
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
      end
      repeat ($urandom_range(1, 25)) step();
    end
    btn_n = 8'hFF;
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
